// File: rtl/reduce_collector.sv
// reduce_collector: multi-slot collector for load-reduce traffic.
// Each slot tracks a node mask, an op and a tag. It folds per-node read
// responses into an accumulator, then hands one finished result at a time
// to the response path through a valid/ready output stage.
module reduce_collector #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TAG_WIDTH  = 8,
    parameter int NUM_SLOTS  = 4,
    parameter int SLOT_BITS  = $clog2(NUM_SLOTS),
    parameter int PORT_BITS  = $clog2(NUM_PORTS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  alloc_valid,
    output logic                  alloc_ready,
    input  logic [NUM_PORTS-1:0]  alloc_mask,
    input  logic [1:0]            alloc_op,
    input  logic [TAG_WIDTH-1:0]  alloc_tag,
    output logic [SLOT_BITS-1:0]  alloc_slot,
    input  logic                  rsp_valid,
    input  logic [PORT_BITS-1:0]  rsp_port,
    input  logic [SLOT_BITS-1:0]  rsp_slot,
    input  logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  done_valid,
    input  logic                  done_ready,
    output logic [SLOT_BITS-1:0]  done_slot,
    output logic [TAG_WIDTH-1:0]  done_tag,
    output logic [DATA_WIDTH-1:0] done_data,
    output logic                  done_error,
    output logic                  err_pulse
);

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_COLLECT = 2'd1,
        SLOT_DONE    = 2'd2
    } slot_state_t;

    slot_state_t           state_q   [NUM_SLOTS];
    slot_state_t           state_d   [NUM_SLOTS];
    logic [NUM_PORTS-1:0]  pending_q [NUM_SLOTS];
    logic [NUM_PORTS-1:0]  pending_d [NUM_SLOTS];
    logic [1:0]            op_q      [NUM_SLOTS];
    logic [1:0]            op_d      [NUM_SLOTS];
    logic [TAG_WIDTH-1:0]  tag_q     [NUM_SLOTS];
    logic [TAG_WIDTH-1:0]  tag_d     [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] acc_q     [NUM_SLOTS];
    logic [DATA_WIDTH-1:0] acc_d     [NUM_SLOTS];
    logic                  first_q   [NUM_SLOTS];
    logic                  first_d   [NUM_SLOTS];
    logic                  empty_q   [NUM_SLOTS];
    logic                  empty_d   [NUM_SLOTS];

    logic                  alloc_fire;
    logic                  rsp_legal;
    logic                  retire;
    logic [NUM_PORTS-1:0]  port_bit;
    logic                  present_hit;
    logic [SLOT_BITS-1:0]  present_slot;

    // Combine the running accumulator with a new operand under the slot's op.
    function automatic logic [DATA_WIDTH-1:0] apply_op(
        input logic [1:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH-1:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = ($signed(a) > $signed(b)) ? a : b;
            2'b10:   r = ($signed(a) < $signed(b)) ? a : b;
            default: r = (a > b) ? a : b;
        endcase
        return r;
    endfunction

    assign alloc_fire = alloc_valid && alloc_ready;
    assign retire     = done_valid && done_ready;
    assign port_bit   = NUM_PORTS'(1) << rsp_port;
    assign rsp_legal  = rsp_valid && (state_q[rsp_slot] == SLOT_COLLECT) &&
                        ((pending_q[rsp_slot] & port_bit) != '0);

    // Grant the lowest-index FREE slot; ready whenever any slot is FREE.
    always_comb begin
        alloc_ready = 1'b0;
        alloc_slot  = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (state_q[s] == SLOT_FREE) begin
                alloc_ready = 1'b1;
                alloc_slot  = SLOT_BITS'(s);
            end
        end
    end

    // Pick the lowest DONE slot to present next, skipping the one retiring now.
    always_comb begin
        present_hit  = 1'b0;
        present_slot = '0;
        for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
            if (state_q[s] == SLOT_DONE && !(retire && done_slot == SLOT_BITS'(s))) begin
                present_hit  = 1'b1;
                present_slot = SLOT_BITS'(s);
            end
        end
    end

    // Per-slot next state: allocation, response folding and retirement act independently.
    always_comb begin
        for (int s = 0; s < NUM_SLOTS; s++) begin
            state_d[s]   = state_q[s];
            pending_d[s] = pending_q[s];
            op_d[s]      = op_q[s];
            tag_d[s]     = tag_q[s];
            acc_d[s]     = acc_q[s];
            first_d[s]   = first_q[s];
            empty_d[s]   = empty_q[s];
            if (alloc_fire && alloc_slot == SLOT_BITS'(s)) begin
                pending_d[s] = alloc_mask;
                op_d[s]      = alloc_op;
                tag_d[s]     = alloc_tag;
                acc_d[s]     = '0;
                first_d[s]   = 1'b1;
                empty_d[s]   = (alloc_mask == '0);
                state_d[s]   = (alloc_mask == '0) ? SLOT_DONE : SLOT_COLLECT;
            end
            if (rsp_legal && rsp_slot == SLOT_BITS'(s)) begin
                acc_d[s]     = first_q[s] ? rsp_data : apply_op(op_q[s], acc_q[s], rsp_data);
                first_d[s]   = 1'b0;
                pending_d[s] = pending_q[s] & ~port_bit;
                if ((pending_q[s] & ~port_bit) == '0) begin
                    state_d[s] = SLOT_DONE;
                end
            end
            if (retire && done_slot == SLOT_BITS'(s)) begin
                state_d[s] = SLOT_FREE;
            end
        end
    end

    // Slot state and payload registers; reset frees every slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state_q[s]   <= SLOT_FREE;
                pending_q[s] <= '0;
                op_q[s]      <= '0;
                tag_q[s]     <= '0;
                acc_q[s]     <= '0;
                first_q[s]   <= 1'b0;
                empty_q[s]   <= 1'b0;
            end
        end else begin
            for (int s = 0; s < NUM_SLOTS; s++) begin
                state_q[s]   <= state_d[s];
                pending_q[s] <= pending_d[s];
                op_q[s]      <= op_d[s];
                tag_q[s]     <= tag_d[s];
                acc_q[s]     <= acc_d[s];
                first_q[s]   <= first_d[s];
                empty_q[s]   <= empty_d[s];
            end
        end
    end

    // Output stage: latch a DONE slot when empty or being emptied, else hold steady.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_valid <= 1'b0;
            done_slot  <= '0;
            done_tag   <= '0;
            done_data  <= '0;
            done_error <= 1'b0;
        end else if (!done_valid || done_ready) begin
            done_valid <= present_hit;
            if (present_hit) begin
                done_slot  <= present_slot;
                done_tag   <= tag_q[present_slot];
                done_data  <= acc_q[present_slot];
                done_error <= empty_q[present_slot];
            end else begin
                done_slot  <= '0;
                done_tag   <= '0;
                done_data  <= '0;
                done_error <= 1'b0;
            end
        end
    end

    // Flag any dropped response for exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= rsp_valid && !rsp_legal;
        end
    end

endmodule

// File: tb/tb_reduce_collector.sv
// Bench for reduce_collector: directed test-plan scenarios plus random
// traffic, checked by a slot-keyed scoreboard and a per-cycle error monitor.
module tb_reduce_collector;

    localparam int NP = 4;
    localparam int DW = 16;
    localparam int TW = 8;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [NP-1:0] alloc_mask;
    logic [1:0]    alloc_op;
    logic [TW-1:0] alloc_tag;
    logic [1:0]    alloc_slot;
    logic          rsp_valid;
    logic [1:0]    rsp_port;
    logic [1:0]    rsp_slot;
    logic [DW-1:0] rsp_data;
    logic          done_valid;
    logic          done_ready;
    logic [1:0]    done_slot;
    logic [TW-1:0] done_tag;
    logic [DW-1:0] done_data;
    logic          done_error;
    logic          err_pulse;

    reduce_collector #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .NUM_SLOTS(NS)
    ) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_mask(alloc_mask),
        .alloc_op(alloc_op), .alloc_tag(alloc_tag), .alloc_slot(alloc_slot),
        .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_slot(rsp_slot), .rsp_data(rsp_data),
        .done_valid(done_valid), .done_ready(done_ready), .done_slot(done_slot),
        .done_tag(done_tag), .done_data(done_data), .done_error(done_error),
        .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: 0 free, 1 collecting, 2 finished awaiting retire.
    int            m_state [NS];
    logic [NP-1:0] m_pend  [NS];
    int            m_op    [NS];
    logic [TW-1:0] m_tag   [NS];
    logic [DW-1:0] m_vals  [NS][NP];
    int            m_cnt   [NS];

    typedef struct {
        int            slot;
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   err_cycles[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reduce a whole list of collected values from the op definition.
    function automatic logic [DW-1:0] fold(input int op, input int n, input logic [DW-1:0] v [NP]);
        longint      total = 0;
        int          sbest;
        int unsigned ubest;
        int          x;
        sbest = $signed(v[0]);
        ubest = v[0];
        for (int i = 0; i < n; i++) begin
            total += v[i];
            x = $signed(v[i]);
            if (op == 1 && x > sbest) sbest = x;
            if (op == 2 && x < sbest) sbest = x;
            if (v[i] > ubest) ubest = v[i];
        end
        case (op)
            0:       return DW'(total % 65536);
            1, 2:    return DW'(sbest);
            default: return DW'(ubest);
        endcase
    endfunction

    task automatic clear_model();
        for (int s = 0; s < NS; s++) begin
            m_state[s] = 0;
            m_pend[s]  = '0;
            m_cnt[s]   = 0;
        end
        sb.delete();
        err_cycles.delete();
    endtask

    task automatic model_response(input int s, input int p, input logic [DW-1:0] d);
        logic [DW-1:0] v [NP];
        if (m_state[s] == 1 && m_pend[s][p]) begin
            m_vals[s][m_cnt[s]] = d;
            m_cnt[s]++;
            m_pend[s][p] = 1'b0;
            if (m_pend[s] == '0) begin
                m_state[s] = 2;
                for (int i = 0; i < NP; i++) v[i] = m_vals[s][i];
                sb.push_back('{s, m_tag[s], fold(m_op[s], m_cnt[s], v), 1'b0});
            end
        end else begin
            err_cycles.push_back(cyc + 1);
        end
    endtask

    // One clock of stimulus; the model consumes the same inputs the DUT will sample.
    task automatic apply_stimulus(input bit a, input logic [NP-1:0] m, input logic [1:0] o,
                                  input logic [TW-1:0] t, input bit r, input int s, input int p,
                                  input logic [DW-1:0] d, input bit rdy);
        int grant;
        bit any_free;
        @(posedge clk);
        #1;
        alloc_valid = a;
        alloc_mask  = m;
        alloc_op    = o;
        alloc_tag   = t;
        rsp_valid   = r;
        rsp_slot    = 2'(s);
        rsp_port    = 2'(p);
        rsp_data    = d;
        done_ready  = rdy;
        if (r) model_response(s, p, d);
        if (a) begin
            any_free = 1'b0;
            grant    = 0;
            for (int i = NS - 1; i >= 0; i--) begin
                if (m_state[i] == 0) begin
                    any_free = 1'b1;
                    grant    = i;
                end
            end
            check("alloc_ready", 32'(alloc_ready), 32'(any_free));
            if (any_free) begin
                check("alloc_slot", 32'(alloc_slot), 32'(grant));
                m_pend[grant] = m;
                m_op[grant]   = o;
                m_tag[grant]  = t;
                m_cnt[grant]  = 0;
                if (m == '0) begin
                    m_state[grant] = 2;
                    sb.push_back('{grant, t, '0, 1'b1});
                end else begin
                    m_state[grant] = 1;
                end
            end
        end
    endtask

    task automatic idle(input bit rdy);
        apply_stimulus(1'b0, '0, '0, '0, 1'b0, 0, 0, '0, rdy);
    endtask

    task automatic do_alloc(input logic [NP-1:0] m, input logic [1:0] o, input logic [TW-1:0] t, input bit rdy);
        apply_stimulus(1'b1, m, o, t, 1'b0, 0, 0, '0, rdy);
    endtask

    task automatic do_rsp(input int s, input int p, input logic [DW-1:0] d, input bit rdy);
        apply_stimulus(1'b0, '0, '0, '0, 1'b1, s, p, d, rdy);
    endtask

    // Assert reset mid-cycle and confirm outputs drop at once, then release it.
    task automatic do_reset();
        @(posedge clk);
        #1;
        reset       = 1'b1;
        alloc_valid = 1'b0;
        rsp_valid   = 1'b0;
        done_ready  = 1'b0;
        #1;
        check("reset_done_valid", 32'(done_valid), 32'd0);
        check("reset_alloc_ready", 32'(alloc_ready), 32'd1);
        check("reset_alloc_slot", 32'(alloc_slot), 32'd0);
        check("reset_err_pulse", 32'(err_pulse), 32'd0);
        check("reset_done_data", 32'(done_data), 32'd0);
        clear_model();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: per-cycle error pulse check and scoreboard pop on each retire.
    always @(negedge clk) begin
        bit exp_err;
        int idx;
        if (!reset) begin
            exp_err = 1'b0;
            if (err_cycles.size() > 0 && err_cycles[0] == cyc) begin
                exp_err = 1'b1;
                void'(err_cycles.pop_front());
            end
            check("err_pulse", 32'(err_pulse), 32'(exp_err));
            if (done_valid && done_ready) begin
                idx = -1;
                foreach (sb[i]) if (idx < 0 && sb[i].slot == int'(done_slot)) idx = i;
                if (idx < 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL done_unexpected: got slot %0d expected no retire", done_slot);
                end else begin
                    check("done_tag", 32'(done_tag), 32'(sb[idx].tag));
                    check("done_data", 32'(done_data), 32'(sb[idx].data));
                    check("done_error", 32'(done_error), 32'(sb[idx].err));
                    sb.delete(idx);
                end
                m_state[done_slot] = 0;
            end
        end
    end

    function automatic logic [DW-1:0] pick_data();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'h7FFF;
            2:       return 16'h8000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Random mix biased toward legal responses, then drain everything.
    task automatic random_phase(input int n);
        int cands[$];
        int ports[$];
        int s;
        int p;
        bit a;
        bit r;
        for (int k = 0; k < n; k++) begin
            cands.delete();
            for (int i = 0; i < NS; i++) if (m_state[i] == 1) cands.push_back(i);
            r = ($urandom_range(0, 9) < 7);
            if (cands.size() > 0 && $urandom_range(0, 3) != 0) begin
                s = cands[$urandom_range(0, cands.size() - 1)];
                ports.delete();
                for (int i = 0; i < NP; i++) if (m_pend[s][i]) ports.push_back(i);
                p = ports[$urandom_range(0, ports.size() - 1)];
            end else begin
                s = $urandom_range(0, NS - 1);
                p = $urandom_range(0, NP - 1);
            end
            a = ($urandom_range(0, 9) < 3);
            apply_stimulus(a, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 8'($urandom),
                           r, s, p, pick_data(), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < NP; j++) begin
                if (m_state[i] == 1 && m_pend[i][j]) do_rsp(i, j, pick_data(), 1'b1);
            end
        end
        for (int k = 0; k < 12; k++) idle(1'b1);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset       = 1'b1;
        alloc_valid = 1'b0;
        alloc_mask  = '0;
        alloc_op    = '0;
        alloc_tag   = '0;
        rsp_valid   = 1'b0;
        rsp_port    = '0;
        rsp_slot    = '0;
        rsp_data    = '0;
        done_ready  = 1'b0;
        clear_model();
        #2;
        check("init_done_valid", 32'(done_valid), 32'd0);
        check("init_alloc_ready", 32'(alloc_ready), 32'd1);
        check("init_err_pulse", 32'(err_pulse), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Four-node SUM with exact completion latency.
        do_alloc(4'b1111, 2'b00, 8'hA1, 1'b0);
        do_rsp(0, 0, 16'd10, 1'b0);
        do_rsp(0, 1, 16'd20, 1'b0);
        do_rsp(0, 2, 16'd30, 1'b0);
        do_rsp(0, 3, 16'd40, 1'b0);
        idle(1'b0);
        check("latency_early", 32'(done_valid), 32'd0);
        idle(1'b0);
        check("latency_valid", 32'(done_valid), 32'd1);
        check("sum4_data", 32'(done_data), 32'd100);
        check("sum4_tag", 32'(done_tag), 32'hA1);
        idle(1'b1);
        idle(1'b0);

        // Op corners, retired straight away.
        do_alloc(4'b0011, 2'b00, 8'h11, 1'b1);
        do_rsp(0, 0, 16'hFFFF, 1'b1);
        do_rsp(0, 1, 16'h0002, 1'b1);
        for (int op = 1; op <= 3; op++) begin
            do_alloc(4'b0111, 2'(op), 8'(8'h20 + op), 1'b1);
            for (int i = 0; i < NS; i++) begin
                if (m_state[i] == 1) begin
                    do_rsp(i, 0, 16'h8000, 1'b1);
                    do_rsp(i, 1, 16'h0005, 1'b1);
                    do_rsp(i, 2, 16'hFFFF, 1'b1);
                end
            end
        end
        for (int k = 0; k < 6; k++) idle(1'b1);
        check("ops_drained", 32'(sb.size()), 32'd0);

        // Fill every slot, then free slot 2 and re-allocate it.
        do_reset();
        for (int i = 0; i < NS; i++) do_alloc(4'b0001, 2'b11, 8'(8'h30 + i), 1'b0);
        do_alloc(4'b0001, 2'b11, 8'h3F, 1'b0);
        do_rsp(2, 0, 16'h1234, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("full_done_slot", 32'(done_slot), 32'd2);
        check("full_done_data", 32'(done_data), 32'h1234);
        do_alloc(4'b0011, 2'b00, 8'h3E, 1'b1);
        do_alloc(4'b0011, 2'b00, 8'h3D, 1'b0);
        check("realloc_slot", 32'(alloc_slot), 32'd2);

        // Illegal responses leave the mask-0011 result untouched.
        do_reset();
        do_rsp(1, 0, 16'h0099, 1'b1);
        do_alloc(4'b0011, 2'b00, 8'h40, 1'b1);
        do_rsp(0, 1, 16'd5, 1'b1);
        do_rsp(0, 1, 16'd7, 1'b1);
        do_rsp(0, 3, 16'd9, 1'b1);
        do_rsp(0, 0, 16'd6, 1'b1);
        for (int k = 0; k < 4; k++) idle(1'b1);
        check("illegal_drained", 32'(sb.size()), 32'd0);

        // Held output stays on slot 1 while slot 0 completes behind it.
        do_reset();
        do_alloc(4'b0001, 2'b01, 8'h50, 1'b0);
        do_alloc(4'b0001, 2'b01, 8'h51, 1'b0);
        do_rsp(1, 0, 16'h0777, 1'b0);
        idle(1'b0);
        idle(1'b0);
        do_rsp(0, 0, 16'h0111, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(1'b0);
            check("hold_valid", 32'(done_valid), 32'd1);
            check("hold_slot", 32'(done_slot), 32'd1);
            check("hold_data", 32'(done_data), 32'h0777);
            check("hold_tag", 32'(done_tag), 32'h51);
        end
        idle(1'b1);
        idle(1'b0);
        check("next_valid", 32'(done_valid), 32'd1);
        check("next_slot", 32'(done_slot), 32'd0);
        check("next_data", 32'(done_data), 32'h0111);
        idle(1'b1);
        idle(1'b0);

        // Reset mid-operation, stale response, then an empty-mask reduction.
        do_alloc(4'b1111, 2'b00, 8'h60, 1'b0);
        do_alloc(4'b0011, 2'b00, 8'h61, 1'b0);
        do_alloc(4'b0000, 2'b00, 8'h62, 1'b0);
        do_rsp(0, 0, 16'd1, 1'b0);
        do_rsp(1, 0, 16'd2, 1'b0);
        idle(1'b0);
        check("pre_reset_valid", 32'(done_valid), 32'd1);
        do_reset();
        do_rsp(0, 1, 16'd3, 1'b0);
        do_alloc(4'b0000, 2'b10, 8'h66, 1'b0);
        idle(1'b0);
        idle(1'b0);
        check("empty_valid", 32'(done_valid), 32'd1);
        check("empty_error", 32'(done_error), 32'd1);
        check("empty_data", 32'(done_data), 32'd0);
        idle(1'b1);
        idle(1'b0);

        random_phase(600);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reduce_collector.md
Name: reduce_collector

Overview:
- Multi-slot collector for CMD_LOAD_REDUCE traffic inside the tiny-switch.
- Tracks up to NUM_SLOTS in-flight reductions, each with its own node mask, op and tag.
- Accumulates per-node read responses with a selectable integer op.
- Emits one completed result per handshake toward the response path. Replaces the single-operation RED_* sequence with parallel slots and multiple ops.

Parameters:
NUM_PORTS, 4, number of nodes; width of masks
DATA_WIDTH, 16, operand/result width
TAG_WIDTH, 8, request tag width
NUM_SLOTS, 4, concurrent reductions (≥2)
SLOT_BITS, $clog2(NUM_SLOTS), derived slot index width
PORT_BITS, $clog2(NUM_PORTS), derived port index width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
alloc_valid  in  1  new reduction request
alloc_ready  out  1  at least one FREE slot
alloc_mask  in  NUM_PORTS  participating nodes
alloc_op  in  2  00 SUM, 01 SMAX, 10 SMIN, 11 UMAX
alloc_tag  in  TAG_WIDTH  request tag, returned on completion
alloc_slot  out  SLOT_BITS  slot granted; valid when alloc_valid&&alloc_ready
rsp_valid  in  1  one node response this cycle (always accepted)
rsp_port  in  PORT_BITS  responding node
rsp_slot  in  SLOT_BITS  target slot
rsp_data  in  DATA_WIDTH  node value
done_valid  out  1  completed result presented
done_ready  in  1  consumer accepts result
done_slot  out  SLOT_BITS  slot being retired
done_tag  out  TAG_WIDTH  tag of that slot
done_data  out  DATA_WIDTH  reduced value
done_error  out  1  slot completed with empty mask
err_pulse  out  1  one-cycle flag: illegal response dropped

Behaviour:
- Reset state: all slots FREE. Outputs done_*=0, err_pulse=0, alloc_slot=0, alloc_ready=1.
- Per-slot state: FREE → COLLECT (alloc) → DONE (pending mask empties) → FREE (retire handshake).
- Per-slot registers: pending mask, op, tag, accumulator, first flag.
- Alloc:
  - alloc_slot = lowest-index FREE slot, combinational.
  - On handshake, the slot loads pending=alloc_mask, op, tag, first=1.
  - alloc_mask==0: slot goes straight to DONE with data 0 and done_error=1.
- Response accepted when slot is COLLECT and pending[rsp_port]=1.
  - If first=1: accumulator=rsp_data. Otherwise accumulator=op(acc, rsp_data).
  - Clear pending bit; clear first.
- Ops:
  - SUM: wraps modulo 2^DATA_WIDTH.
  - SMAX/SMIN: two's-complement compare.
  - UMAX: unsigned compare.
- Latency: the response that clears the last pending bit at edge t gives done_valid=1 after edge t+1 (one registered stage).
- Illegal response (slot FREE or DONE, port not in mask, or duplicate port):
  - Dropped with no state change.
  - err_pulse=1 for exactly the cycle after it.
- Output selection:
  - When done_valid=0, the lowest-index DONE slot is latched.
  - The latched slot is held with stable done_* until done_ready=1, even if a lower-index slot reaches DONE meanwhile.
  - At the accepting edge the slot becomes FREE; the next DONE slot can present the following cycle.
- Freed slot is not allocatable in the same cycle as its retire; alloc_ready reflects it next cycle.
- Same cycle alloc + response + retire on different slots: all take effect independently.
- alloc_valid with alloc_ready=0: ignored; upstream holds.
- Reset mid-operation: all slots FREE immediately; pending results discarded; outputs return to reset values asynchronously.

Test Plan:
- mask=1111, SUM, responses 10,20,30,40 on ports 0-3 → done_data=100, done_tag matches, done_valid exactly 1 cycle after 4th response.
- SUM 0xFFFF+0x0002 → 0x0001. SMAX {0x8000,0x0005,0xFFFF} → 0x0005. SMIN same set → 0x8000. UMAX same set → 0xFFFF.
- 4 allocs with no responses → alloc_slot 0,1,2,3, then alloc_ready=0. Complete and retire slot 2 → alloc_ready=1 next cycle and next alloc_slot=2.
- Illegal responses: to a FREE slot, duplicate port 1, port 3 outside mask 0011 → err_pulse 1 cycle each; final result for mask 0011 unaffected.
- done_ready=0, slot 1 completes then slot 0 → output holds slot 1 with stable data. done_ready=1 → slot 1 retires, slot 0 presented next cycle.
- Reset asserted with 2 slots in COLLECT → done_valid=0 and alloc_ready=1 immediately. Stale response after reset → err_pulse. mask=0000 alloc → done_error=1, data 0.
